localbus_fanout: RTL and testbench
==================================

// Module: localbus_fanout
// PURPOSE
//  Parametrised local-bus splitter: one master localbus (PS AXI bridge side) fans out to NSLAVE
//  address windows (cfg regs, dsp regs, BRAM ctrl, ...), each with its own fixed read delay.
//  Read returns are re-aligned to one uniform latency, so rvalid/rvalidlast are in order.
//  Next step after per-bus mappin with a single READDELAY; sits between lbN map and the slaves.
// PARAMETERS
//  DATA_WIDTH   32          data width, master and all slaves
//  ADDR_WIDTH   24          master address width
//  NSLAVE       4           number of slave windows, 1..16
//  SEL_WIDTH    2           top address bits used as window select; 2**SEL_WIDTH >= NSLAVE
//  RDMAX        8           aligned read delay budget, 1..15; every RDDLY entry <= RDMAX
//  RDDLY        {4'd5,4'd3,4'd1,4'd5}  packed per-slave read delay, slave 0 in bits[3:0]; each 1..RDMAX
//  UNMAPPED     32'hDEADBEEF  read data for sel >= NSLAVE
// PORTS
//  clk           in   1                     bus clock
//  reset         in   1                     async, active-high
//  m_wren        in   1                     master write strobe
//  m_waddr       in   ADDR_WIDTH            master write address
//  m_wdata       in   DATA_WIDTH            master write data
//  m_rden        in   1                     master read strobe, one read per cycle
//  m_rdenlast    in   1                     last beat of burst, qualified by m_rden
//  m_raddr       in   ADDR_WIDTH            master read address
//  m_rdata       out  DATA_WIDTH            read data, qualified by m_rvalid
//  m_rvalid      out  1                     read data valid
//  m_rvalidlast  out  1                     tag of m_rdenlast, qualified by m_rvalid
//  s_wren        out  NSLAVE                one-hot per-slave write strobe
//  s_waddr       out  ADDR_WIDTH-SEL_WIDTH  window-local write address, broadcast
//  s_wdata       out  DATA_WIDTH            write data, broadcast
//  s_rden        out  NSLAVE                one-hot per-slave read strobe
//  s_raddr       out  ADDR_WIDTH-SEL_WIDTH  window-local read address, broadcast
//  s_rdata       in   NSLAVE*DATA_WIDTH     slave i data in [i*DATA_WIDTH +: DATA_WIDTH]
//  err_clr       in   1                     sync pulse, clears err_cnt
//  err_cnt       out  16                    count of unmapped accesses, saturating
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. On reset all outputs go to 0, err_cnt
//    goes to 0, the read tag pipeline is flushed, and in-flight reads never return.
//  - sel = addr[ADDR_WIDTH-1 -: SEL_WIDTH]; local addr = remaining low bits.
//  - Write path: registered, 1 cycle. m_wren at cycle t -> s_wren[sel], s_waddr, s_wdata at t+1.
//    If sel >= NSLAVE: no strobe, write dropped, err_cnt += 1.
//  - Read issue: registered. m_rden at t -> s_rden[sel] and s_raddr at t+1. Unmapped: no strobe.
//  - Slave contract: slave i drives s_rdata[i] valid exactly RDDLY[i] cycles after its s_rden.
//  - Tag pipeline: stages 0..RDMAX, with {valid, last, sel, unmapped, data}, shifting every cycle.
//    Stage 0 is loaded at t+1.
//    When a valid tag at stage k has sel=i and k==RDDLY[i], it captures s_rdata[i] into the tag data.
//    Unmapped tags load UNMAPPED at stage 0.
//  - Return: m_rvalid=1 at exactly t+RDMAX+2 for every window, with m_rdata = the captured data
//    and m_rvalidlast = the registered m_rdenlast. Otherwise m_rvalid=0, m_rvalidlast=0, and
//    m_rdata holds its last value.
//  - Throughput is 1 read/cycle; mixed-window back-to-back reads return in issue order with no gaps
//    added. m_rden and m_wren in the same cycle issue independently, even to the same slave.
//  - err_cnt: +1 per unmapped read or write, +2 if both occur in one cycle, saturating at 16'hFFFF.
//    If err_clr and an error occur in the same cycle, err_cnt = errors of that cycle (clear first).
//  - Parameter check: any RDDLY entry of 0 or > RDMAX, or 2**SEL_WIDTH < NSLAVE, is an
//    elaboration $error.
//  - Reset asserted mid-burst: the remaining tags are discarded. After release, the first
//    m_rvalid is only for a read issued after release.
// TESTING
//  1) Write 0x1234 to addr {2'd2,local 0x10} -> s_wren=4'b0100, s_waddr=0x10, s_wdata=0x1234 at t+1.
//  2) Reads to slaves 0,1,2,3 on consecutive cycles with delays 5,1,3,5 -> m_rvalid at t+10..t+13,
//     data in issue order.
//  3) 8-beat burst to slave 1 with rdenlast on beat 8 -> 8 contiguous m_rvalid; m_rvalidlast
//     only on the 8th.
//  4) NSLAVE=3, read sel=3 -> no s_rden, m_rdata=0xDEADBEEF at t+RDMAX+2, err_cnt=1; err_clr
//     plus simultaneous unmapped write -> err_cnt=1.
//  5) Force err_cnt to 0xFFFE, then 3 unmapped accesses -> 0xFFFF held.
//  6) Assert reset 2 cycles into a 4-read burst -> all outputs 0 and no m_rvalid for the burst;
//     a new read after release returns at t+RDMAX+2.

Source files
------------

// File: rtl/localbus_fanout_if.sv
// Local-bus fan-out bundle: the upstream master request/return signals plus the
// per-window slave strobes and read data.
interface localbus_fanout_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 24,
    parameter int NSLAVE     = 4,
    parameter int SEL_WIDTH  = 2
);
    logic                            m_wren;
    logic [ADDR_WIDTH-1:0]           m_waddr;
    logic [DATA_WIDTH-1:0]           m_wdata;
    logic                            m_rden;
    logic                            m_rdenlast;
    logic [ADDR_WIDTH-1:0]           m_raddr;
    logic [DATA_WIDTH-1:0]           m_rdata;
    logic                            m_rvalid;
    logic                            m_rvalidlast;
    logic [NSLAVE-1:0]               s_wren;
    logic [ADDR_WIDTH-SEL_WIDTH-1:0] s_waddr;
    logic [DATA_WIDTH-1:0]           s_wdata;
    logic [NSLAVE-1:0]               s_rden;
    logic [ADDR_WIDTH-SEL_WIDTH-1:0] s_raddr;
    logic [NSLAVE*DATA_WIDTH-1:0]    s_rdata;

    modport master (
        output m_wren, m_waddr, m_wdata, m_rden, m_rdenlast, m_raddr, s_rdata,
        input  m_rdata, m_rvalid, m_rvalidlast, s_wren, s_waddr, s_wdata, s_rden, s_raddr
    );

    modport slave (
        input  m_wren, m_waddr, m_wdata, m_rden, m_rdenlast, m_raddr, s_rdata,
        output m_rdata, m_rvalid, m_rvalidlast, s_wren, s_waddr, s_wdata, s_rden, s_raddr
    );
endinterface

// File: rtl/localbus_fanout.sv
// Local-bus splitter: one master bus fanned out to NSLAVE address windows, with every
// window's read return re-aligned to a single fixed latency of RDMAX+2 cycles.
module localbus_fanout_param_chk #(
    parameter int                  NSLAVE    = 4,
    parameter int                  SEL_WIDTH = 2,
    parameter int                  RDMAX     = 8,
    parameter logic [4*NSLAVE-1:0] RDDLY     = 16'h5315
);
    if (NSLAVE < 1 || NSLAVE > 16) begin : g_bad_nslave
        $error("localbus_fanout: NSLAVE=%0d outside 1..16", NSLAVE);
    end
    if ((1 << SEL_WIDTH) < NSLAVE) begin : g_bad_sel
        $error("localbus_fanout: SEL_WIDTH=%0d cannot address NSLAVE=%0d", SEL_WIDTH, NSLAVE);
    end
    if (RDMAX < 1 || RDMAX > 15) begin : g_bad_rdmax
        $error("localbus_fanout: RDMAX=%0d outside 1..15", RDMAX);
    end
    for (genvar i = 0; i < NSLAVE; i++) begin : g_dly
        if (RDDLY[i*4 +: 4] == 4'd0 || int'(RDDLY[i*4 +: 4]) > RDMAX) begin : g_bad
            $error("localbus_fanout: read delay of slave %0d outside 1..RDMAX", i);
        end
    end
endmodule

module localbus_fanout #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 24,
    parameter int                    NSLAVE     = 4,
    parameter int                    SEL_WIDTH  = 2,
    parameter int                    RDMAX      = 8,
    parameter logic [4*NSLAVE-1:0]   RDDLY      = 16'h5315,
    parameter logic [DATA_WIDTH-1:0] UNMAPPED   = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             reset,
    localbus_fanout_if.slave bus,
    input  logic             err_clr,
    output logic [15:0]      err_cnt
);
    localparam int LW = ADDR_WIDTH - SEL_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic                  unm;
        logic [SEL_WIDTH-1:0]  sel;
        logic [DATA_WIDTH-1:0] data;
    } tag_t;

    function automatic logic is_unmapped(input logic [SEL_WIDTH-1:0] sel);
        logic unm;
        unm = 1'b1;
        for (int i = 0; i < NSLAVE; i++) begin
            if (sel == SEL_WIDTH'(i)) unm = 1'b0;
        end
        return unm;
    endfunction

    function automatic logic [3:0] dly_of(input logic [SEL_WIDTH-1:0] sel);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (sel == SEL_WIDTH'(i)) d = RDDLY[i*4 +: 4];
        end
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rdata_of(input logic [SEL_WIDTH-1:0]         sel,
                                                      input logic [NSLAVE*DATA_WIDTH-1:0] rd);
        logic [DATA_WIDTH-1:0] d;
        d = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NSLAVE; i++) begin
            if (sel == SEL_WIDTH'(i)) d = rd[i*DATA_WIDTH +: DATA_WIDTH];
        end
        return d;
    endfunction

    localbus_fanout_param_chk #(
        .NSLAVE(NSLAVE), .SEL_WIDTH(SEL_WIDTH), .RDMAX(RDMAX), .RDDLY(RDDLY)
    ) u_param_chk ();

    logic [SEL_WIDTH-1:0]  wsel_s, rsel_s;
    logic                  wunm_s, runm_s;
    logic [NSLAVE-1:0]     wren_nx_s, rden_nx_s;
    tag_t                  new_tag_s;
    tag_t                  cap_s [0:RDMAX];
    tag_t                  tag_r [0:RDMAX];
    logic [1:0]            err_inc_s;
    logic [15:0]           err_base_s, err_nx_s;
    logic [16:0]           err_sum_s;
    logic [NSLAVE-1:0]     s_wren_r, s_rden_r;
    logic [LW-1:0]         s_waddr_r, s_raddr_r;
    logic [DATA_WIDTH-1:0] s_wdata_r, m_rdata_r;
    logic                  m_rvalid_r, m_rvalidlast_r;
    logic [15:0]           err_cnt_r;

    assign wsel_s = bus.m_waddr[ADDR_WIDTH-1 -: SEL_WIDTH];
    assign rsel_s = bus.m_raddr[ADDR_WIDTH-1 -: SEL_WIDTH];
    assign wunm_s = is_unmapped(wsel_s);
    assign runm_s = is_unmapped(rsel_s);

    // Window decode, new read tag and saturating error-count update.
    always_comb begin
        wren_nx_s = {NSLAVE{1'b0}};
        rden_nx_s = {NSLAVE{1'b0}};
        for (int i = 0; i < NSLAVE; i++) begin
            wren_nx_s[i] = bus.m_wren && (wsel_s == SEL_WIDTH'(i));
            rden_nx_s[i] = bus.m_rden && (rsel_s == SEL_WIDTH'(i));
        end
        new_tag_s.valid = bus.m_rden;
        new_tag_s.last  = bus.m_rden && bus.m_rdenlast;
        new_tag_s.unm   = runm_s;
        new_tag_s.sel   = rsel_s;
        if (runm_s) begin
            new_tag_s.data = UNMAPPED;
        end else begin
            new_tag_s.data = {DATA_WIDTH{1'b0}};
        end
        err_inc_s = {1'b0, bus.m_wren && wunm_s} + {1'b0, bus.m_rden && runm_s};
        if (err_clr) begin
            err_base_s = 16'd0;
        end else begin
            err_base_s = err_cnt_r;
        end
        err_sum_s = {1'b0, err_base_s} + {15'd0, err_inc_s};
        if (err_sum_s[16]) begin
            err_nx_s = 16'hFFFF;
        end else begin
            err_nx_s = err_sum_s[15:0];
        end
    end

    // Each tag grabs its slave's data in the one stage where that slave's delay has elapsed.
    always_comb begin
        for (int k = 0; k <= RDMAX; k++) begin
            cap_s[k] = tag_r[k];
            if (tag_r[k].valid && !tag_r[k].unm && (dly_of(tag_r[k].sel) == 4'(k))) begin
                cap_s[k].data = rdata_of(tag_r[k].sel, bus.s_rdata);
            end else begin
                cap_s[k].data = tag_r[k].data;
            end
        end
    end

    // Registered slave-side strobes and broadcast address/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_wren_r  <= {NSLAVE{1'b0}};
            s_rden_r  <= {NSLAVE{1'b0}};
            s_waddr_r <= {LW{1'b0}};
            s_raddr_r <= {LW{1'b0}};
            s_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            s_wren_r <= wren_nx_s;
            s_rden_r <= rden_nx_s;
            if (bus.m_wren) begin
                s_waddr_r <= bus.m_waddr[LW-1:0];
                s_wdata_r <= bus.m_wdata;
            end
            if (bus.m_rden) begin
                s_raddr_r <= bus.m_raddr[LW-1:0];
            end
        end
    end

    // Tag pipeline: reset flushes every in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= RDMAX; k++) begin
                tag_r[k] <= {$bits(tag_t){1'b0}};
            end
        end else begin
            tag_r[0] <= new_tag_s;
            for (int k = 1; k <= RDMAX; k++) begin
                tag_r[k] <= cap_s[k-1];
            end
        end
    end

    // Aligned master return and error counter; rdata holds between returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rvalid_r     <= 1'b0;
            m_rvalidlast_r <= 1'b0;
            m_rdata_r      <= {DATA_WIDTH{1'b0}};
            err_cnt_r      <= 16'd0;
        end else begin
            m_rvalid_r     <= cap_s[RDMAX].valid;
            m_rvalidlast_r <= cap_s[RDMAX].valid && cap_s[RDMAX].last;
            if (cap_s[RDMAX].valid) begin
                m_rdata_r <= cap_s[RDMAX].data;
            end
            err_cnt_r <= err_nx_s;
        end
    end

    assign bus.s_wren       = s_wren_r;
    assign bus.s_rden       = s_rden_r;
    assign bus.s_waddr      = s_waddr_r;
    assign bus.s_raddr      = s_raddr_r;
    assign bus.s_wdata      = s_wdata_r;
    assign bus.m_rdata      = m_rdata_r;
    assign bus.m_rvalid     = m_rvalid_r;
    assign bus.m_rvalidlast = m_rvalidlast_r;
    assign err_cnt          = err_cnt_r;
endmodule

// File: tb/tb_localbus_fanout.sv
// Bench for localbus_fanout: a 4-window instance and a 3-window instance (with an
// unmapped window) driven by directed vectors, read returns checked by a scoreboard.
module tb_localbus_fanout;
    localparam int DW    = 32;
    localparam int AW    = 24;
    localparam int SW    = 2;
    localparam int RDMAX = 8;
    localparam int DLY4 [4] = '{5, 1, 3, 5};
    localparam int DLY3 [3] = '{5, 1, 3};

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_clr4, err_clr3;
    logic [15:0] err_cnt4, err_cnt3;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        q4[$];
    exp_t        q3[$];
    logic [31:0] hold [2];
    logic        sv4 [4][16];
    logic [31:0] sd4 [4][16];
    logic        sv3 [3][16];
    logic [31:0] sd3 [3][16];

    localbus_fanout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NSLAVE(4), .SEL_WIDTH(SW)) bus4 ();
    localbus_fanout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NSLAVE(3), .SEL_WIDTH(SW)) bus3 ();

    localbus_fanout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NSLAVE(4), .SEL_WIDTH(SW), .RDMAX(RDMAX),
                      .RDDLY(16'h5315), .UNMAPPED(32'hDEADBEEF))
        dut4 (.clk(clk), .reset(rst), .bus(bus4), .err_clr(err_clr4), .err_cnt(err_cnt4));
    localbus_fanout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NSLAVE(3), .SEL_WIDTH(SW), .RDMAX(RDMAX),
                      .RDDLY(12'h315), .UNMAPPED(32'hDEADBEEF))
        dut3 (.clk(clk), .reset(rst), .bus(bus3), .err_clr(err_clr3), .err_cnt(err_cnt3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_data(input int s, input logic [21:0] a);
        return {s[3:0], 6'h2A, a};
    endfunction

    // Slave models: data valid exactly DLY cycles after the strobe, garbage otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) for (int k = 0; k < 16; k++) sv4[i][k] <= 1'b0;
            for (int i = 0; i < 3; i++) for (int k = 0; k < 16; k++) sv3[i][k] <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sv4[i][0] <= bus4.s_rden[i];
                sd4[i][0] <= model_data(i, bus4.s_raddr);
                for (int k = 1; k < 16; k++) begin
                    sv4[i][k] <= sv4[i][k-1];
                    sd4[i][k] <= sd4[i][k-1];
                end
            end
            for (int i = 0; i < 3; i++) begin
                sv3[i][0] <= bus3.s_rden[i];
                sd3[i][0] <= model_data(i, bus3.s_raddr);
                for (int k = 1; k < 16; k++) begin
                    sv3[i][k] <= sv3[i][k-1];
                    sd3[i][k] <= sd3[i][k-1];
                end
            end
        end
    end

    always_comb begin
        bus4.s_rdata = {128{1'b0}};
        bus3.s_rdata = {96{1'b0}};
        for (int i = 0; i < 4; i++)
            bus4.s_rdata[i*32 +: 32] = sv4[i][DLY4[i]-1] ? sd4[i][DLY4[i]-1] : (32'hBAD0_0000 | 32'(i));
        for (int i = 0; i < 3; i++)
            bus3.s_rdata[i*32 +: 32] = sv3[i][DLY3[i]-1] ? sd3[i][DLY3[i]-1] : (32'hBAD0_0000 | 32'(i));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic mon_step(input int w, input logic v, input logic l, input logic [31:0] d);
        exp_t e;
        int   sz;
        sz = (w == 0) ? q4.size() : q3.size();
        if (v) begin
            if (sz == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid[%0d] @cyc %0d: got rdata %0h, required no return", w, cyc, d);
            end else begin
                if (w == 0) e = q4.pop_front();
                else        e = q3.pop_front();
                chk("rdata", d, e.data);
                chk("rvalidlast", l, e.last);
                chk("rvalid_cycle", cyc, e.due);
                hold[w] = e.data;
            end
        end else begin
            chk("rvalidlast_idle", l, 0);
            chk("rdata_hold", d, hold[w]);
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            hold[0] = 32'd0;
            hold[1] = 32'd0;
        end
        mon_step(0, bus4.m_rvalid, bus4.m_rvalidlast, bus4.m_rdata);
        mon_step(1, bus3.m_rvalid, bus3.m_rvalidlast, bus3.m_rdata);
    end

    task automatic step();
        @(negedge clk);
        bus4.m_wren = 1'b0; bus4.m_rden = 1'b0; bus4.m_rdenlast = 1'b0;
        bus3.m_wren = 1'b0; bus3.m_rden = 1'b0; bus3.m_rdenlast = 1'b0;
        err_clr4 = 1'b0; err_clr3 = 1'b0;
    endtask

    task automatic rd4(input int s, input logic [21:0] a, input logic last);
        exp_t e;
        bus4.m_rden = 1'b1; bus4.m_rdenlast = last; bus4.m_raddr = {2'(s), a};
        e.data = model_data(s, a); e.last = last; e.due = cyc + RDMAX + 2;
        q4.push_back(e);
    endtask

    task automatic rd3(input int s, input logic [21:0] a);
        exp_t e;
        bus3.m_rden = 1'b1; bus3.m_rdenlast = 1'b0; bus3.m_raddr = {2'(s), a};
        e.data = (s >= 3) ? 32'hDEADBEEF : model_data(s, a); e.last = 1'b0; e.due = cyc + RDMAX + 2;
        q3.push_back(e);
    endtask

    task automatic wr4(input int s, input logic [21:0] a, input logic [31:0] d);
        bus4.m_wren = 1'b1; bus4.m_waddr = {2'(s), a}; bus4.m_wdata = d;
    endtask

    task automatic wr3(input int s, input logic [21:0] a, input logic [31:0] d);
        bus3.m_wren = 1'b1; bus3.m_waddr = {2'(s), a}; bus3.m_wdata = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus4.m_wren = 1'b0; bus4.m_rden = 1'b0; bus4.m_rdenlast = 1'b0;
        bus4.m_waddr = 24'd0; bus4.m_wdata = 32'd0; bus4.m_raddr = 24'd0;
        bus3.m_wren = 1'b0; bus3.m_rden = 1'b0; bus3.m_rdenlast = 1'b0;
        bus3.m_waddr = 24'd0; bus3.m_wdata = 32'd0; bus3.m_raddr = 24'd0;
        err_clr4 = 1'b0; err_clr3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_wren", bus4.s_wren, 0);
        chk("rst_s_rden", bus4.s_rden, 0);
        chk("rst_m_rvalid", bus4.m_rvalid, 0);
        chk("rst_m_rdata", bus4.m_rdata, 0);
        chk("rst_err_cnt", err_cnt3, 0);
        rst = 1'b0;
        step();

        // Mapped write to window 2
        wr4(2, 22'h10, 32'h1234);
        step();
        chk("wr_strobe", bus4.s_wren, 4'b0100);
        chk("wr_addr", bus4.s_waddr, 22'h10);
        chk("wr_data", bus4.s_wdata, 32'h1234);
        chk("wr_no_rden", bus4.s_rden, 0);
        step();
        chk("wr_strobe_clear", bus4.s_wren, 0);

        // Read and write to the same slave in one cycle
        wr4(1, 22'h3, 32'hCAFE0001);
        rd4(1, 22'h7, 1'b0);
        step();
        chk("rw_wren", bus4.s_wren, 4'b0010);
        chk("rw_rden", bus4.s_rden, 4'b0010);
        chk("rw_raddr", bus4.s_raddr, 22'h7);
        chk("rw_waddr", bus4.s_waddr, 22'h3);

        // Back-to-back reads across all windows
        for (int i = 0; i < 4; i++) begin
            rd4(i, 22'h100 + 22'(i), 1'b0);
            step();
            chk("rd_strobe", bus4.s_rden, 64'd1 << i);
        end
        repeat (12) step();

        // 8-beat burst to window 1, last on the final beat
        for (int b = 0; b < 8; b++) begin
            rd4(1, 22'h20 + 22'(b), b == 7);
            step();
        end
        repeat (12) step();
        chk("err_cnt4_zero", err_cnt4, 0);

        // Unmapped window on the 3-slave instance
        rd3(3, 22'h55);
        step();
        chk("unm_no_rden", bus3.s_rden, 3'b000);
        chk("err_unm_rd", err_cnt3, 1);
        rd3(2, 22'h66);
        wr3(2, 22'h9, 32'h5A5A);
        step();
        chk("dut3_rden", bus3.s_rden, 3'b100);
        chk("dut3_wren", bus3.s_wren, 3'b100);
        chk("err_mapped_hold", err_cnt3, 1);
        repeat (11) step();
        err_clr3 = 1'b1;
        wr3(3, 22'h1, 32'h1);
        step();
        chk("err_clr_with_err", err_cnt3, 1);
        chk("unm_no_wren", bus3.s_wren, 3'b000);
        rd3(3, 22'h2);
        wr3(3, 22'h2, 32'h0);
        step();
        chk("err_plus2", err_cnt3, 3);
        err_clr3 = 1'b1;
        step();
        chk("err_clr", err_cnt3, 0);

        // Saturation: two errors per cycle up to 0xFFFE, then three more
        for (int k = 0; k < 32767; k++) begin
            rd3(3, 22'(k));
            wr3(3, 22'(k), 32'(k));
            step();
        end
        chk("err_fffe", err_cnt3, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            wr3(3, 22'h4, 32'h0);
            step();
            chk("err_sat", err_cnt3, 16'hFFFF);
        end
        rd3(3, 22'h5);
        wr3(3, 22'h5, 32'h0);
        step();
        chk("err_sat2", err_cnt3, 16'hFFFF);
        err_clr3 = 1'b1;
        step();
        chk("err_clr_sat", err_cnt3, 0);
        repeat (12) step();

        // Reset in the middle of a burst
        rd4(0, 22'h200, 1'b0);
        step();
        rd4(1, 22'h201, 1'b0);
        step();
        rst = 1'b1;
        q4.delete();
        q3.delete();
        #1;
        chk("mid_rst_s_rden", bus4.s_rden, 0);
        chk("mid_rst_s_raddr", bus4.s_raddr, 0);
        chk("mid_rst_s_wdata", bus4.s_wdata, 0);
        chk("mid_rst_m_rvalid", bus4.m_rvalid, 0);
        chk("mid_rst_m_rdata", bus4.m_rdata, 0);
        chk("mid_rst_err_cnt", err_cnt3, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (15) step();
        rd4(3, 22'h300, 1'b1);
        step();

        for (int k = 0; k < 40 && (q4.size() + q3.size()) > 0; k++) step();
        chk("pending_returns", q4.size() + q3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
